// File: rtl/if_id_pkg.sv
// Shared widths, NOP encoding and handshake state type for the fetch/decode skid stage.
package if_id_pkg;

  localparam int unsigned PC_W_DEF   = 32;
  localparam int unsigned INST_W_DEF = 32;
  localparam logic [31:0] NOP_INST   = '0;

  typedef enum logic [1:0] {EMPTY, ONE, TWO} stage_state_t;

endpackage

// File: rtl/if_id_skid_stage_entry.sv
// One held beat of the fetch/decode stage: LANES slots of pc/inst.
// Slots whose lane_valid bit is clear are stored as pc=0 and a NOP instruction.
module stage_entry
  import if_id_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned LANES  = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    clear,
  input  logic [LANES-1:0]        lane_valid_d,
  input  logic [LANES*PC_W-1:0]   pc_d,
  input  logic [LANES*INST_W-1:0] inst_d,
  output logic [LANES-1:0]        lane_valid,
  output logic [LANES*PC_W-1:0]   pc,
  output logic [LANES*INST_W-1:0] inst
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      lane_valid <= '0;
      pc         <= '0;
      inst       <= '0;
    end else if (load) begin
      lane_valid <= lane_valid_d;
      for (int unsigned i = 0; i < LANES; i++) begin
        pc[i*PC_W +: PC_W]       <= lane_valid_d[i] ? pc_d[i*PC_W +: PC_W] : '0;
        inst[i*INST_W +: INST_W] <= lane_valid_d[i] ? inst_d[i*INST_W +: INST_W]
                                                    : INST_W'(NOP_INST);
      end
    end
  end

endmodule

// File: rtl/if_id_skid_stage.sv
// Elastic fetch/decode register: valid/ready handshake with a two-entry skid
// (main drives decode, skid holds the younger overflow beat), flush and stall counter.
module if_id_skid_stage
  import if_id_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEF,
  parameter int unsigned INST_W = INST_W_DEF,
  parameter int unsigned LANES  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [LANES-1:0]        in_lane_valid,
  input  logic [LANES*PC_W-1:0]   in_pc,
  input  logic [LANES*INST_W-1:0] in_inst,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [LANES-1:0]        out_lane_valid,
  output logic [LANES*PC_W-1:0]   out_pc,
  output logic [LANES*INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]        stall_cycles
);

  stage_state_t state, next_state;

  logic accept, drain;
  logic main_load, main_clear, main_from_skid;
  logic skid_load, skid_clear;

  logic [LANES-1:0]        skid_lane_valid;
  logic [LANES*PC_W-1:0]   skid_pc;
  logic [LANES*INST_W-1:0] skid_inst;

  logic [LANES-1:0]        main_lane_valid_d;
  logic [LANES*PC_W-1:0]   main_pc_d;
  logic [LANES*INST_W-1:0] main_inst_d;

  // in_ready comes straight from the state register, so out_ready never reaches it.
  assign in_ready  = (state != TWO);
  assign out_valid = (state != EMPTY);

  // Beats with no valid slot complete the handshake but are not stored.
  assign accept = in_valid && in_ready && (|in_lane_valid);
  assign drain  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  always_comb begin
    next_state     = state;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      next_state = EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            next_state = ONE;
            main_load  = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            main_load = 1'b1;
          end else if (accept) begin
            next_state = TWO;
            skid_load  = 1'b1;
          end else if (drain) begin
            next_state = EMPTY;
            main_clear = 1'b1;
          end
        end
        TWO: begin
          if (drain) begin
            next_state     = ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: next_state = EMPTY;
      endcase
    end
  end

  assign main_lane_valid_d = main_from_skid ? skid_lane_valid : in_lane_valid;
  assign main_pc_d         = main_from_skid ? skid_pc         : in_pc;
  assign main_inst_d       = main_from_skid ? skid_inst       : in_inst;

  stage_entry #(.PC_W(PC_W), .INST_W(INST_W), .LANES(LANES)) u_main (
    .clk          (clk),
    .rst          (rst),
    .load         (main_load),
    .clear        (main_clear),
    .lane_valid_d (main_lane_valid_d),
    .pc_d         (main_pc_d),
    .inst_d       (main_inst_d),
    .lane_valid   (out_lane_valid),
    .pc           (out_pc),
    .inst         (out_inst)
  );

  stage_entry #(.PC_W(PC_W), .INST_W(INST_W), .LANES(LANES)) u_skid (
    .clk          (clk),
    .rst          (rst),
    .load         (skid_load),
    .clear        (skid_clear),
    .lane_valid_d (in_lane_valid),
    .pc_d         (in_pc),
    .inst_d       (in_inst),
    .lane_valid   (skid_lane_valid),
    .pc           (skid_pc),
    .inst         (skid_inst)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (out_valid && !out_ready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule
